// File: rtl/serial_out_pkg.sv
// Shared constants for the serial transmitter: frame bit values, FSM encodings
// and the bit-period helper.
package serial_out_pkg;

  localparam logic SERIAL_START_BIT = 1'b0;
  localparam logic SERIAL_STOP_BIT  = 1'b1;
  localparam int   SERIAL_DATA_BITS = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_START = 2'd1;
  localparam state_t ST_DATA  = 2'd2;
  localparam state_t ST_STOP  = 2'd3;

  // Clock cycles per line bit; truncation is intentional.
  function automatic int bit_ticks(input int clk_hz, input int bps);
    return clk_hz / bps;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous FIFO with a combinational head read; shared by the transmit
// path and intended for a future receive buffer.
module byte_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = DEPTH[DEPTH_LOG2:0];

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  wr_ok;
  logic                  rd_ok;

  // Full/empty come from the registered count, so a same-cycle pop never
  // makes room for a write.
  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign wr_ok   = wr_en & ~full;
  assign rd_ok   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/serial_out.sv
// 8N1 serial transmitter: byte strobe into a FIFO, frames shifted out LSB first
// on a registered tx line that idles high.
//
// state    | meaning
// ST_IDLE  | line idle high, waiting for a queued byte
// ST_START | start bit on the line
// ST_DATA  | data bits 0..7, LSB first
// ST_STOP  | stop bit; pops the next byte on its last cycle if one is queued
module serial_out
  import serial_out_pkg::*;
#(
  parameter int CLK_FREQUENCY_HZ = 108_000_000,
  parameter int SERIAL_BPS       = 1_000_000,
  parameter int FIFO_DEPTH_LOG2  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       ie,
  output logic       full,
  output logic       overflow,
  output logic       busy,
  output logic       tx
);

  localparam int BIT_TICKS = bit_ticks(CLK_FREQUENCY_HZ, SERIAL_BPS);
  localparam int CNT_W     = (BIT_TICKS < 2) ? 1 : $clog2(BIT_TICKS);
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(BIT_TICKS - 1);
  localparam logic [2:0]       LAST_BIT  = 3'(SERIAL_DATA_BITS - 1);

  generate
    if (BIT_TICKS < 2) begin : g_bad_rate
      $error("serial_out: CLK_FREQUENCY_HZ / SERIAL_BPS must be at least 2");
    end
  endgenerate

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic [7:0]       head;
  logic             fifo_empty;
  logic             last_tick;
  logic             pop;
  logic             line_bit;

  assign last_tick = (baud_cnt == LAST_TICK);
  assign pop  = ~fifo_empty & ((state == ST_IDLE) | ((state == ST_STOP) & last_tick));
  assign busy = (state != ST_IDLE) | ~fifo_empty;

  byte_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (ie),
    .wr_data (data),
    .rd_en   (pop),
    .rd_data (head),
    .empty   (fifo_empty),
    .full    (full)
  );

  always_comb begin
    line_bit = SERIAL_STOP_BIT;
    case (state)
      ST_START: line_bit = SERIAL_START_BIT;
      ST_DATA:  line_bit = shift[0];
      default:  line_bit = SERIAL_STOP_BIT;
    endcase
  end

  // tx is registered off the state, so the line lags the FSM by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      overflow <= 1'b0;
    end else begin
      tx       <= line_bit;
      overflow <= ie & full;
      if (pop) shift <= head;
      case (state)
        ST_IDLE: begin
          baud_cnt <= '0;
          if (pop) state <= ST_START;
        end
        ST_START: begin
          if (last_tick) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (last_tick) begin
            baud_cnt <= '0;
            shift    <= {1'b0, shift[7:1]};
            if (bit_idx == LAST_BIT) state <= ST_STOP;
            else                     bit_idx <= bit_idx + 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (last_tick) begin
            baud_cnt <= '0;
            state    <= pop ? ST_START : ST_IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_out.sv
// Directed bench for serial_out: default-rate instance with a reference UART
// receiver, plus a 3-cycle-per-bit instance for an exact waveform check.
module tb_serial_out;

  localparam int T  = 108;
  localparam int T3 = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data = 8'h00;
  logic       ie = 1'b0;
  logic [7:0] data3 = 8'h00;
  logic       ie3 = 1'b0;
  logic       full, overflow, busy, tx;
  logic       full3, overflow3, busy3, tx3;

  int errors = 0;
  int checks = 0;

  serial_out dut (
    .clk      (clk),
    .reset    (reset),
    .data     (data),
    .ie       (ie),
    .full     (full),
    .overflow (overflow),
    .busy     (busy),
    .tx       (tx)
  );

  serial_out #(
    .CLK_FREQUENCY_HZ (1000),
    .SERIAL_BPS       (300)
  ) dut3 (
    .clk      (clk),
    .reset    (reset),
    .data     (data3),
    .ie       (ie3),
    .full     (full3),
    .overflow (overflow3),
    .busy     (busy3),
    .tx       (tx3)
  );

  always #5 clk = ~clk;

  // Reference receiver: mid-bit sampling of the default-rate line.
  int         rx_t = 0;
  bit         rx_active = 1'b0;
  bit         rx_bad = 1'b0;
  logic [7:0] rx_sh = 8'h00;
  logic       rx_clear = 1'b0;
  int         rx_q[$];

  always @(negedge clk) begin
    if (rx_clear || reset) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (tx === 1'b0) begin
        rx_active = 1'b1;
        rx_t = 0;
        rx_bad = 1'b0;
      end
    end else begin
      rx_t++;
      if (rx_t % T == T / 2) begin
        if (rx_t / T == 0) rx_bad = rx_bad | (tx !== 1'b0);
        else if (rx_t / T <= 8) rx_sh[rx_t / T - 1] = tx;
        else begin
          rx_q.push_back((tx === 1'b1 && !rx_bad) ? int'(rx_sh) : -1);
          rx_active = 1'b0;
        end
      end
    end
  end

  task automatic write_byte(input logic [7:0] b);
    data = b;
    ie = 1'b1;
    @(negedge clk);
    ie = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1)       begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (full !== 1'b0)     begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    checks++; if (tx3 !== 1'b1)      begin errors++; $display("FAIL reset_tx3: got %b want 1", tx3); end
    checks++; if (busy3 !== 1'b0)    begin errors++; $display("FAIL reset_busy3: got %b want 0", busy3); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single;
    logic [9:0] frame;
    int bad[10];
    frame = {1'b1, 8'h55, 1'b0};
    for (int j = 0; j < 10; j++) bad[j] = 0;
    rx_q.delete();
    write_byte(8'h55);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_on_write: got %b want 1", busy); end
    checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL single_tx_n0: got %b want 1", tx); end
    @(negedge clk);
    checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL single_tx_n1: got %b want 1", tx); end
    @(negedge clk);
    // FSM enters START one edge before tx falls; busy follows the FSM.
    for (int k = 0; k < 10 * T; k++) begin
      if (tx !== frame[k / T]) bad[k / T]++;
      if (k == 10 * T - 2) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_hold: got %b want 1", busy); end
      end
      if (k == 10 * T - 1) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_drop: got %b want 0", busy); end
      end
      if (k < 10 * T - 1) @(negedge clk);
    end
    for (int j = 0; j < 10; j++) begin
      checks++;
      if (bad[j] != 0) begin
        errors++;
        $display("FAIL single_bit%0d: %0d cycles differ, want level %b for %0d cycles", j, bad[j], frame[j], T);
      end
    end
    repeat (5) @(negedge clk);
    checks++;
    if (rx_q.size() != 1 || rx_q[0] != 32'h55) begin
      errors++;
      $display("FAIL single_rx: got %0d bytes first=%0h, want 1 byte 55", rx_q.size(), rx_q.size() > 0 ? rx_q[0] : -1);
    end
  endtask

  task automatic test_back_to_back;
    int n = 0;
    rx_q.delete();
    data = 8'h41;
    ie = 1'b1;
    @(negedge clk);
    data = 8'h0D;
    @(negedge clk);
    ie = 1'b0;
    while (tx !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n != 1) begin errors++; $display("FAIL b2b_first_start: after %0d cycles, want 1", n); end
    repeat (10 * T - 1) @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL b2b_last_stop: got %b want 1", tx); end
    @(negedge clk);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL b2b_no_gap: got %b want 0", tx); end
    wait_idle(3000);
    checks++;
    if (rx_q.size() != 2 || rx_q[0] != 32'h41 || rx_q[1] != 32'h0D) begin
      errors++;
      $display("FAIL b2b_rx: got %0d bytes, want 41 then 0d", rx_q.size());
    end
  endtask

  task automatic test_overflow;
    int ovf = 0;
    int bad = 0;
    rx_q.delete();
    for (int i = 0; i < 20; i++) begin
      data = (i < 17) ? 8'(8'h10 + i) : 8'(8'hE0 + i);
      ie = 1'b1;
      @(negedge clk);
      if (overflow === 1'b1) ovf++;
      if (i == 15) begin
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL ovf_not_full_15: got %b want 0", full); end
      end
      if (i == 16) begin
        checks++; if (full !== 1'b1)     begin errors++; $display("FAIL ovf_full_16: got %b want 1", full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_17th_accepted: got %b want 0", overflow); end
      end
      if (i == 17) begin
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse_18th: got %b want 1", overflow); end
      end
    end
    ie = 1'b0;
    @(negedge clk);
    if (overflow === 1'b1) ovf++;
    checks++; if (ovf != 3) begin errors++; $display("FAIL ovf_pulse_count: got %0d want 3", ovf); end
    wait_idle(20000);
    checks++;
    if (rx_q.size() != 17) begin errors++; $display("FAIL ovf_rx_count: got %0d want 17", rx_q.size()); end
    for (int i = 0; i < rx_q.size() && i < 17; i++) if (rx_q[i] != 8'h10 + i) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL ovf_rx_order: %0d bytes differ from 10..20", bad); end
  endtask

  task automatic test_full_pop;
    int bad = 0;
    rx_q.delete();
    for (int i = 0; i < 17; i++) begin
      data = 8'(8'h60 + i);
      ie = 1'b1;
      @(negedge clk);
    end
    ie = 1'b0;
    // Park on the cycle before the first STOP->START pop.
    repeat (10 * T - 16) @(negedge clk);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fullpop_full_before: got %b want 1", full); end
    data = 8'h99;
    ie = 1'b1;
    @(negedge clk);
    ie = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fullpop_overflow: got %b want 1", overflow); end
    checks++; if (full !== 1'b0)     begin errors++; $display("FAIL fullpop_count_dec: full=%b want 0", full); end
    @(negedge clk);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_single_pulse: got %b want 0", overflow); end
    wait_idle(20000);
    checks++;
    if (rx_q.size() != 17) begin errors++; $display("FAIL fullpop_rx_count: got %0d want 17", rx_q.size()); end
    for (int i = 0; i < rx_q.size() && i < 17; i++) if (rx_q[i] != 8'h60 + i) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL fullpop_rx_order: %0d bytes differ from 60..70", bad); end
  endtask

  task automatic test_slow_rate;
    logic [9:0] frame;
    int bad[10];
    frame = {1'b1, 8'hA3, 1'b0};
    for (int j = 0; j < 10; j++) bad[j] = 0;
    data3 = 8'hA3;
    ie3 = 1'b1;
    @(negedge clk);
    ie3 = 1'b0;
    @(negedge clk);
    checks++; if (tx3 !== 1'b1) begin errors++; $display("FAIL slow_tx_n1: got %b want 1", tx3); end
    @(negedge clk);
    for (int k = 0; k < 10 * T3; k++) begin
      if (tx3 !== frame[k / T3]) bad[k / T3]++;
      if (k == 10 * T3 - 2) begin
        checks++; if (busy3 !== 1'b1) begin errors++; $display("FAIL slow_busy_hold: got %b want 1", busy3); end
      end
      if (k == 10 * T3 - 1) begin
        checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL slow_busy_drop: got %b want 0", busy3); end
      end
      @(negedge clk);
    end
    for (int j = 0; j < 10; j++) begin
      checks++;
      if (bad[j] != 0) begin
        errors++;
        $display("FAIL slow_bit%0d: %0d cycles differ, want level %b for %0d cycles", j, bad[j], frame[j], T3);
      end
    end
    checks++; if (tx3 !== 1'b1) begin errors++; $display("FAIL slow_idle_after: got %b want 1", tx3); end
  endtask

  task automatic test_reset_mid;
    data = 8'hF0;
    ie = 1'b1;
    @(negedge clk);
    data = 8'h0F;
    @(negedge clk);
    ie = 1'b0;
    // Middle of data bit 3 of 0xF0 (a 0 on the line).
    repeat (T * 4 + 55) @(negedge clk);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL midreset_bit3: got %b want 0", tx); end
    reset = 1'b1;
    rx_clear = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL midreset_tx: got %b want 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", busy); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL midreset_full: got %b want 0", full); end
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_queue_lost: busy=%b want 0", busy); end
    rx_clear = 1'b0;
    rx_q.delete();
    write_byte(8'h3C);
    wait_idle(3000);
    checks++;
    if (rx_q.size() != 1 || rx_q[0] != 32'h3C) begin
      errors++;
      $display("FAIL midreset_after: got %0d bytes, want 1 byte 3c", rx_q.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    wait_idle(3000);
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_slow_rate();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
